// File: rtl/adda_pkg.sv
// Shared definitions for the ADDA hand-drawn waveform path.
package adda_pkg;

  // Default geometry of the point buffer and the phase accumulator
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int FRAC_W_DEF = 16;

  // Unsigned mid-scale DAC code, used whenever the output is parked
  localparam logic [7:0] MID_CODE = 8'h80;

  // Playback sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CALC,
    OUT
  } player_state_t;

endpackage

// File: rtl/hand_drawn_lerp.sv
// Combinational linear interpolation between two adjacent waveform points.
// Result = s0 + floor((s1 - s0) * frac8 / 256), clamped to the unsigned range.
module hand_drawn_lerp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_s0,
  input  logic [DATA_W-1:0] i_s1,
  input  logic [7:0]        i_frac8,
  output logic [DATA_W-1:0] o_sample
);

  // Wide enough for s0 plus a full-scale signed correction term
  localparam logic signed [DATA_W+8:0] L_MAX = {9'b0, {DATA_W{1'b1}}};

  logic signed [DATA_W:0]   w_diff;
  logic signed [DATA_W+8:0] w_prod;
  logic signed [DATA_W+8:0] w_sum;

  assign w_diff = $signed({1'b0, i_s1}) - $signed({1'b0, i_s0});
  assign w_prod = w_diff * $signed({1'b0, i_frac8});
  // Arithmetic shift floors negative corrections toward minus infinity
  assign w_sum  = $signed({9'b0, i_s0}) + (w_prod >>> 8);

  // Clamp the interpolated value into 0..2^DATA_W-1
  always_comb begin
    // NOTE: output gets a default before any branch so no latch is inferred.
    o_sample = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W+8]) begin
      o_sample = '0;
    end else if (w_sum > L_MAX) begin
      o_sample = '1;
    end
  end

endmodule

// File: rtl/hand_drawn_player.sv
// Playback engine: walks the hand-drawn point buffer with a fractional phase
// accumulator and emits one interpolated DAC sample per accepted tick.
module hand_drawn_player
  import adda_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sample_tick,
  input  logic [ADDR_W:0]          point_count,
  input  logic [ADDR_W+FRAC_W-1:0] phase_step,
  output logic [ADDR_W-1:0]        ram_adb,
  output logic                     ram_ceb,
  output logic                     ram_oce,
  input  logic [DATA_W-1:0]        ram_dout,
  output logic [DATA_W-1:0]        dac_data,
  output logic                     dac_valid,
  output logic                     tick_overrun
);

  localparam int PH_W = ADDR_W + FRAC_W;
  localparam logic [DATA_W-1:0] L_MID = DATA_W'(MID_CODE);

  player_state_t     r_state;
  logic [PH_W-1:0]   r_phase;
  logic [ADDR_W:0]   r_pc;
  logic [PH_W-1:0]   r_step;
  logic [DATA_W-1:0] r_s0;
  logic [DATA_W-1:0] r_dac_data;
  logic              r_dac_valid;
  logic [ADDR_W-1:0] r_ram_adb;
  logic              r_ram_ceb;
  logic              r_overrun;

  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W:0]   w_idx_inc;
  logic [ADDR_W-1:0] w_i1;
  logic [7:0]        w_frac8;
  logic [PH_W:0]     w_pc_lim;
  logic              w_step_big;
  logic [PH_W-1:0]   w_step_lat;
  logic [PH_W:0]     w_ph_sum;
  logic              w_ph_wrap;
  logic [PH_W-1:0]   w_ph_next;
  logic              w_tick_ok;
  logic              w_accept;
  logic              w_busy;
  logic [DATA_W-1:0] w_lerp;

  // Current point and its successor, wrapping at the latched loop length
  assign w_idx     = r_phase[PH_W-1:FRAC_W];
  assign w_idx_inc = {1'b0, w_idx} + (ADDR_W+1)'(1);
  assign w_i1      = (w_idx_inc == r_pc) ? '0 : w_idx_inc[ADDR_W-1:0];
  assign w_frac8   = r_phase[FRAC_W-1:FRAC_W-8];

  // A step of a whole loop or more is pulled just below one loop so that a
  // single subtraction always brings the phase back into range
  assign w_pc_lim   = {point_count, FRAC_W'(0)};
  assign w_step_big = ({1'b0, phase_step} >= w_pc_lim);
  assign w_step_lat = w_step_big ? PH_W'(w_pc_lim - (PH_W+1)'(1)) : phase_step;

  // Next phase: one extra bit keeps phase + step from overflowing
  assign w_ph_sum  = {1'b0, r_phase} + {1'b0, r_step};
  assign w_ph_wrap = (w_ph_sum[PH_W:FRAC_W] >= r_pc);
  assign w_ph_next = PH_W'(w_ph_wrap ? (w_ph_sum - {r_pc, FRAC_W'(0)}) : w_ph_sum);

  assign w_tick_ok = sample_tick && enable && (point_count != '0);
  assign w_accept  = w_tick_ok && ((r_state == IDLE) || (r_state == OUT));
  assign w_busy    = (r_state == RD0) || (r_state == RD1) || (r_state == CALC);

  // s1 is taken straight off the RAM data bus during CALC so the registered
  // sample lands in the OUT cycle, four cycles after the accepted tick
  hand_drawn_lerp #(
    .DATA_W (DATA_W)
  ) u_lerp (
    .i_s0     (r_s0),
    .i_s1     (ram_dout),
    .i_frac8  (w_frac8),
    .o_sample (w_lerp)
  );

  // Sequencer, phase accumulator and registered RAM/DAC outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_pc        <= '0;
      r_step      <= '0;
      r_s0        <= '0;
      r_dac_data  <= L_MID;
      r_dac_valid <= 1'b0;
      r_ram_adb   <= '0;
      r_ram_ceb   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // NOTE: every state register here uses <= so all updates see pre-edge values.
      r_dac_valid <= 1'b0;
      if (sample_tick && w_busy) begin
        r_overrun <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RD0;
          end else if (!enable) begin
            r_phase    <= '0;
            r_dac_data <= L_MID;
          end else if (sample_tick) begin
            // Empty buffer: park the output without touching the RAM
            r_phase     <= '0;
            r_dac_data  <= L_MID;
            r_dac_valid <= 1'b1;
          end
        end
        RD0: begin
          r_ram_adb <= w_i1;
          r_ram_ceb <= 1'b1;
          r_state   <= RD1;
        end
        RD1: begin
          r_s0      <= ram_dout;
          r_ram_ceb <= 1'b0;
          r_state   <= CALC;
        end
        CALC: begin
          r_dac_data  <= w_lerp;
          r_dac_valid <= 1'b1;
          r_phase     <= w_ph_next;
          r_state     <= OUT;
        end
        OUT: begin
          r_state <= w_accept ? RD0 : IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Accepting a tick latches the sample's loop length and step and
      // issues the first read at the current integer index
      if (w_accept) begin
        r_pc      <= point_count;
        r_step    <= w_step_lat;
        r_ram_adb <= w_idx;
        r_ram_ceb <= 1'b1;
      end
    end
  end

  assign ram_adb      = r_ram_adb;
  assign ram_ceb      = r_ram_ceb;
  assign ram_oce      = 1'b1;
  assign dac_data     = r_dac_data;
  assign dac_valid    = r_dac_valid;
  assign tick_overrun = r_overrun;

endmodule
